chen_frame_tx: RTL and testbench

Frame transmitter for the data_en/data streaming interface. Accepts words from an upstream source under a valid/ready handshake and buffers them in a two-bank (ping-pong) RAM. Emits each complete frame as a contiguous burst of exactly FRAME_LENGTH words on data_en_o/data_o, with a fixed idle gap between frames. This is the source-side counterpart of the frame-buffer FIFO: its output drives that block's data_en_i/data_i.

---
 rtl/chen_frame_tx_pkg.sv | 9 +
 rtl/chen_frame_tx_ram.sv | 29 ++
 rtl/chen_frame_tx.sv | 168 ++++++++++++++++
 tb/tb_chen_frame_tx.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chen_frame_tx_pkg.sv
// rtl/chen_frame_tx_pkg.sv - shared read-FSM state encodings for the frame transmitter
package chen_frame_tx_pkg;

   // Read-side FSM states (legacy-compatible plain constants)
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BURST = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;

endpackage

// File: rtl/chen_frame_tx_ram.sv
// rtl/chen_frame_tx_ram.sv - two-bank simple dual-port frame RAM with registered read
module chen_frame_tx_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   // Address is {bank, index}; the bank bit is the MSB so each bank is a
   // power-of-two window even when the frame length is not.
   logic [DATA_WIDTH-1:0] mem_q [0:(2**ADDR_WIDTH)-1];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Synchronous write and one-cycle registered read; no reset on storage
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/chen_frame_tx.sv
// rtl/chen_frame_tx.sv - ping-pong buffered frame transmitter for the data_en/data interface
module chen_frame_tx
   import chen_frame_tx_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int FRAME_LENGTH   = 255,
   parameter int RAM_ADDR_WIDTH = 8,
   parameter int IFG            = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   input  logic [DATA_WIDTH-1:0] s_data_i,
   input  logic                  flush_i,
   output logic                  data_en_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  sof_o,
   output logic                  eof_o
);

   localparam int BANK_BIT = RAM_ADDR_WIDTH;
   localparam int GW       = (IFG > 1) ? $clog2(IFG) : 1;
   localparam logic [RAM_ADDR_WIDTH-1:0] LAST_IDX = RAM_ADDR_WIDTH'(FRAME_LENGTH - 1);
   localparam logic [GW-1:0]             GAP_LAST = GW'((IFG > 0) ? IFG - 1 : 0);

   // Write side
   logic                      wbank_q, wbank_d;
   logic [RAM_ADDR_WIDTH-1:0] windex_q, windex_d;
   logic [1:0]                bank_full_q, bank_full_d;
   logic                      wr_fire, wr_last;

   // Read side
   logic [1:0]                state_q, state_d;
   logic                      rbank_q, rbank_d;
   logic [RAM_ADDR_WIDTH-1:0] rindex_q, rindex_d;
   logic [GW-1:0]             gcnt_q, gcnt_d;
   logic                      rd_act, rd_clr, next_rbank;

   // Output pipeline aligned with the RAM read latency
   logic                      en_q, sof_q, eof_q;
   logic [DATA_WIDTH-1:0]     ram_rdata;
   logic [BANK_BIT:0]         waddr, raddr;

   assign s_ready_o  = ~bank_full_q[wbank_q];
   assign wr_fire    = s_valid_i & s_ready_o & ~flush_i;
   assign wr_last    = wr_fire & (windex_q == LAST_IDX);
   assign next_rbank = ~rbank_q;
   assign waddr      = {wbank_q, windex_q};
   assign raddr      = {rbank_q, rindex_q};

   // Write pointer: flush rewinds the partial frame, completion hands the bank to the reader
   always_comb begin
      wbank_d  = wbank_q;
      windex_d = windex_q;
      if (flush_i) begin
         windex_d = '0;
      end else if (wr_fire) begin
         if (windex_q == LAST_IDX) begin
            windex_d = '0;
            wbank_d  = ~wbank_q;
         end else begin
            windex_d = windex_q + 1'b1;
         end
      end
   end

   // Read FSM: wait for a full bank, stream it, then hold the inter-frame gap
   always_comb begin
      state_d  = state_q;
      rbank_d  = rbank_q;
      rindex_d = rindex_q;
      gcnt_d   = gcnt_q;
      rd_act   = 1'b0;
      rd_clr   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bank_full_q[rbank_q]) begin
               state_d  = ST_BURST;
               rindex_d = '0;
            end
         end
         ST_BURST: begin
            rd_act   = 1'b1;
            rindex_d = rindex_q + 1'b1;
            if (rindex_q == LAST_IDX) begin
               rd_clr   = 1'b1;
               rbank_d  = next_rbank;
               rindex_d = '0;
               if (IFG > 0) begin
                  state_d = ST_GAP;
                  gcnt_d  = '0;
               end else if (bank_full_q[next_rbank]) begin
                  state_d = ST_BURST;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            gcnt_d = gcnt_q + 1'b1;
            if (gcnt_q == GAP_LAST) begin
               rindex_d = '0;
               state_d  = bank_full_q[rbank_q] ? ST_BURST : ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Bank ownership flags: writer sets on frame completion, reader clears after the last word
   always_comb begin
      bank_full_d = bank_full_q;
      if (wr_last) begin
         bank_full_d[wbank_q] = 1'b1;
      end
      if (rd_clr) begin
         bank_full_d[rbank_q] = 1'b0;
      end
   end

   // State registers with asynchronous active-low clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wbank_q     <= 1'b0;
         windex_q    <= '0;
         bank_full_q <= 2'b00;
         state_q     <= ST_IDLE;
         rbank_q     <= 1'b0;
         rindex_q    <= '0;
         gcnt_q      <= '0;
         en_q        <= 1'b0;
         sof_q       <= 1'b0;
         eof_q       <= 1'b0;
      end else begin
         wbank_q     <= wbank_d;
         windex_q    <= windex_d;
         bank_full_q <= bank_full_d;
         state_q     <= state_d;
         rbank_q     <= rbank_d;
         rindex_q    <= rindex_d;
         gcnt_q      <= gcnt_d;
         en_q        <= rd_act;
         sof_q       <= rd_act & (rindex_q == '0);
         eof_q       <= rd_act & (rindex_q == LAST_IDX);
      end
   end

   chen_frame_tx_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (RAM_ADDR_WIDTH + 1)
   ) u_ram (
      .clk     (clk),
      .we_i    (wr_fire),
      .waddr_i (waddr),
      .wdata_i (s_data_i),
      .raddr_i (raddr),
      .rdata_o (ram_rdata)
   );

   assign data_en_o = en_q;
   assign sof_o     = sof_q;
   assign eof_o     = eof_q;
   assign data_o    = en_q ? ram_rdata : '0;

endmodule

// File: tb/tb_chen_frame_tx.sv
// tb/tb_chen_frame_tx.sv - self-checking bench for chen_frame_tx
module tb_chen_frame_tx;

   localparam int DW  = 8;
   localparam int FL  = 4;
   localparam int IFG = 2;
   localparam int AW  = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          s_valid_i = 1'b0;
   logic          s_ready_o;
   logic [DW-1:0] s_data_i = '0;
   logic          flush_i = 1'b0;
   logic          data_en_o;
   logic [DW-1:0] data_o;
   logic          sof_o, eof_o;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   chen_frame_tx #(
      .DATA_WIDTH     (DW),
      .FRAME_LENGTH   (FL),
      .RAM_ADDR_WIDTH (AW),
      .IFG            (IFG)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid_i (s_valid_i),
      .s_ready_o (s_ready_o),
      .s_data_i  (s_data_i),
      .flush_i   (flush_i),
      .data_en_o (data_en_o),
      .data_o    (data_o),
      .sof_o     (sof_o),
      .eof_o     (eof_o)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Output log
   logic [DW-1:0] obs_d[$];
   bit            obs_sof[$];
   bit            obs_eof[$];
   int            obs_c[$];
   int            idle_nonzero = 0;
   int            notready_cycles = 0;

   // Reference model: accepted words are held until a frame completes
   logic [DW-1:0] part_q[$];
   logic [DW-1:0] exp_q[$];

   always @(negedge clk) begin
      if (rst) begin
         if (data_en_o) begin
            obs_d.push_back(data_o);
            obs_sof.push_back(sof_o);
            obs_eof.push_back(eof_o);
            obs_c.push_back(cyc);
         end else if (data_o !== '0 || sof_o !== 1'b0 || eof_o !== 1'b0) begin
            idle_nonzero++;
         end
         if (!s_ready_o) notready_cycles++;
      end
   end

   function automatic void model_accept(input logic [DW-1:0] d);
      part_q.push_back(d);
      if (part_q.size() == FL) begin
         foreach (part_q[i]) exp_q.push_back(part_q[i]);
         part_q.delete();
      end
   endfunction

   function automatic void model_flush();
      part_q.delete();
   endfunction

   // Frame structure violations in the log: sof/eof placement and intra-frame contiguity
   function automatic int shape_errs();
      int e = 0;
      foreach (obs_d[i]) begin
         if (obs_sof[i] != ((i % FL) == 0)) e++;
         if (obs_eof[i] != ((i % FL) == FL - 1)) e++;
         if ((i % FL) != 0 && obs_c[i] != obs_c[i-1] + 1) e++;
      end
      if ((obs_d.size() % FL) != 0) e++;
      return e;
   endfunction

   function automatic int gap_min();
      int g = 1000;
      for (int k = FL; k < obs_c.size(); k += FL)
         if (obs_c[k] - obs_c[k-1] - 1 < g) g = obs_c[k] - obs_c[k-1] - 1;
      return g;
   endfunction

   function automatic int gap_max();
      int g = -1;
      for (int k = FL; k < obs_c.size(); k += FL)
         if (obs_c[k] - obs_c[k-1] - 1 > g) g = obs_c[k] - obs_c[k-1] - 1;
      return g;
   endfunction

   task automatic clear_log();
      obs_d.delete(); obs_sof.delete(); obs_eof.delete(); obs_c.delete();
      idle_nonzero = 0;
      notready_cycles = 0;
   endtask

   task automatic do_reset();
      s_valid_i = 1'b0;
      flush_i   = 1'b0;
      rst       = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      part_q.delete();
      exp_q.delete();
      clear_log();
      @(posedge clk);
      #1;
   endtask

   // Present one word and hold it until accepted; e returns the accepting edge count
   task automatic send(input logic [DW-1:0] d, output int e);
      bit done = 1'b0;
      e = -1;
      s_valid_i = 1'b1;
      s_data_i  = d;
      for (int t = 0; t < 100 && !done; t++) begin
         bit acc;
         acc = s_ready_o && !flush_i;
         @(posedge clk);
         #1;
         if (acc) begin
            done = 1'b1;
            e = cyc;
            model_accept(d);
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL send_timeout: accepted=%0d required=1 data=%h", done, d);
      end
   endtask

   task automatic idle(input int n);
      s_valid_i = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      s_valid_i = 1'b0;
      repeat (60) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      s_valid_i = 1'b0;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checks++; if (data_en_o !== 1'b0) begin errors++; $display("FAIL reset_data_en: got=%b exp=0", data_en_o); end
      checks++; if (data_o !== '0)      begin errors++; $display("FAIL reset_data: got=%h exp=00", data_o); end
      checks++; if (sof_o !== 1'b0)     begin errors++; $display("FAIL reset_sof: got=%b exp=0", sof_o); end
      checks++; if (eof_o !== 1'b0)     begin errors++; $display("FAIL reset_eof: got=%b exp=0", eof_o); end
      checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got=%b exp=1", s_ready_o); end
      #1 rst = 1'b1;
      clear_log();
      repeat (10) @(posedge clk);
      #1;
      checks++; if (obs_d.size() != 0) begin errors++; $display("FAIL reset_quiet: words=%0d exp=0", obs_d.size()); end
      checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got=%b exp=1", s_ready_o); end
   endtask

   task automatic test_single_frame();
      logic [DW-1:0] w[4];
      int e;
      w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44;
      do_reset();
      foreach (w[i]) send(w[i], e);
      idle(1);
      drain();
      checks++;
      if (obs_d.size() != FL) begin
         errors++; $display("FAIL single_count: got=%0d exp=%0d", obs_d.size(), FL);
      end else begin
         foreach (w[i]) begin
            checks++;
            if (obs_d[i] !== w[i]) begin errors++; $display("FAIL single_word%0d: got=%h exp=%h", i, obs_d[i], w[i]); end
         end
         checks++;
         if (obs_c[0] != e + 2) begin errors++; $display("FAIL single_latency: first_edge=%0d exp=%0d", obs_c[0], e + 2); end
      end
      checks++; if (shape_errs() != 0) begin errors++; $display("FAIL single_shape: violations=%0d exp=0", shape_errs()); end
      checks++; if (idle_nonzero != 0) begin errors++; $display("FAIL single_idle_zero: violations=%0d exp=0", idle_nonzero); end
   endtask

   task automatic test_back_to_back();
      int e;
      do_reset();
      for (int i = 1; i <= 12; i++) send(DW'(i), e);
      idle(1);
      drain();
      checks++; if (notready_cycles == 0) begin errors++; $display("FAIL b2b_backpressure: notready_cycles=%0d exp>0", notready_cycles); end
      checks++;
      if (obs_d.size() != 12) begin
         errors++; $display("FAIL b2b_count: got=%0d exp=12", obs_d.size());
      end else begin
         for (int i = 0; i < 12; i++) begin
            checks++;
            if (obs_d[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_word%0d: got=%h exp=%h", i, obs_d[i], exp_q[i]); end
         end
      end
      checks++; if (shape_errs() != 0) begin errors++; $display("FAIL b2b_shape: violations=%0d exp=0", shape_errs()); end
      checks++; if (gap_min() != IFG)  begin errors++; $display("FAIL b2b_gap_min: got=%0d exp=%0d", gap_min(), IFG); end
      checks++; if (gap_max() != IFG)  begin errors++; $display("FAIL b2b_gap_max: got=%0d exp=%0d", gap_max(), IFG); end
   endtask

   task automatic test_gappy_input();
      int e;
      do_reset();
      for (int i = 5; i <= 8; i++) begin
         send(DW'(i), e);
         idle(1);
      end
      drain();
      checks++;
      if (obs_d.size() != FL) begin
         errors++; $display("FAIL gappy_count: got=%0d exp=%0d", obs_d.size(), FL);
      end else begin
         for (int i = 0; i < FL; i++) begin
            checks++;
            if (obs_d[i] !== DW'(i + 5)) begin errors++; $display("FAIL gappy_word%0d: got=%h exp=%h", i, obs_d[i], DW'(i + 5)); end
         end
      end
      checks++; if (shape_errs() != 0) begin errors++; $display("FAIL gappy_shape: violations=%0d exp=0", shape_errs()); end
   endtask

   task automatic test_flush();
      int e;
      do_reset();
      send(8'h0A, e);
      send(8'h0B, e);
      s_valid_i = 1'b0;
      flush_i = 1'b1;
      @(posedge clk);
      #1 flush_i = 1'b0;
      model_flush();
      for (int i = 1; i <= 4; i++) send(DW'(i), e);
      idle(1);
      drain();
      checks++;
      if (obs_d.size() != FL) begin
         errors++; $display("FAIL flush_count: got=%0d exp=%0d", obs_d.size(), FL);
      end else begin
         for (int i = 0; i < FL; i++) begin
            checks++;
            if (obs_d[i] !== DW'(i + 1)) begin errors++; $display("FAIL flush_word%0d: got=%h exp=%h", i, obs_d[i], DW'(i + 1)); end
         end
      end
      checks++; if (shape_errs() != 0) begin errors++; $display("FAIL flush_shape: violations=%0d exp=0", shape_errs()); end
   endtask

   task automatic test_async_reset();
      int  e;
      bit  seen = 1'b0;
      do_reset();
      for (int i = 0; i < FL; i++) send(DW'($urandom), e);
      idle(1);
      for (int t = 0; t < 20 && !seen; t++) begin
         if (data_en_o) seen = 1'b1;
         else begin @(posedge clk); #1; end
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL async_burst_start: seen=%0d exp=1", seen); end
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      checks++; if (data_en_o !== 1'b0) begin errors++; $display("FAIL async_data_en: got=%b exp=0", data_en_o); end
      checks++; if (data_o !== '0)      begin errors++; $display("FAIL async_data: got=%h exp=00", data_o); end
      checks++; if ((sof_o | eof_o) !== 1'b0) begin errors++; $display("FAIL async_flags: sof=%b eof=%b exp=0", sof_o, eof_o); end
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      part_q.delete();
      exp_q.delete();
      clear_log();
      @(posedge clk);
      #1;
      checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL async_ready: got=%b exp=1", s_ready_o); end
      repeat (20) @(posedge clk);
      #1;
      checks++; if (obs_d.size() != 0) begin errors++; $display("FAIL async_residual: words=%0d exp=0", obs_d.size()); end
   endtask

   task automatic test_random();
      int e;
      int mism = 0;
      do_reset();
      for (int n = 0; n < 80; n++) begin
         int r;
         r = $urandom_range(0, 19);
         if (r == 0) begin
            // flush coinciding with an offered word: the word must be discarded
            s_valid_i = 1'b1;
            s_data_i  = DW'($urandom);
            flush_i   = 1'b1;
            @(posedge clk);
            #1 flush_i = 1'b0;
            s_valid_i = 1'b0;
            model_flush();
         end else if (r < 6) begin
            idle($urandom_range(1, 3));
         end else begin
            send(DW'($urandom), e);
         end
      end
      idle(1);
      drain();
      checks++;
      if (obs_d.size() != exp_q.size()) begin
         errors++; $display("FAIL rand_count: got=%0d exp=%0d", obs_d.size(), exp_q.size());
      end
      for (int i = 0; i < obs_d.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_d[i] !== exp_q[i]) begin
            errors++; mism++;
            if (mism <= 8) $display("FAIL rand_word%0d: got=%h exp=%h", i, obs_d[i], exp_q[i]);
         end
      end
      checks++; if (shape_errs() != 0) begin errors++; $display("FAIL rand_shape: violations=%0d exp=0", shape_errs()); end
      checks++; if (gap_min() < IFG)   begin errors++; $display("FAIL rand_gap: min_gap=%0d exp>=%0d", gap_min(), IFG); end
      checks++; if (idle_nonzero != 0) begin errors++; $display("FAIL rand_idle_zero: violations=%0d exp=0", idle_nonzero); end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_gappy_input();
      test_flush();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
